data_mem_access_ctrl: RTL and testbench

//  Initiator side of the synchronous data-memory port (1-cycle registered read, write on we at clk edge).

---
 rtl/data_mem_pkg.sv | 16 +
 rtl/byte_lane_merge.sv | 36 +++
 rtl/data_mem_access_ctrl.sv | 124 ++++++++++++
 tb/tb_data_mem_access_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared definitions for the data-memory access controller: FSM states,
// word width and byte-lane select width.
package data_mem_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int LANE_SEL_WIDTH = 2;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAPTURE,
    WR,
    RESP
  } state_t;

endpackage

// File: rtl/byte_lane_merge.sv
// Little-endian byte-lane helper: replaces one lane of a word with a new byte
// (store RMW) and extracts that lane zero-extended (byte load).
module byte_lane_merge
  import data_mem_pkg::*;
(
  input  logic [DATA_WIDTH-1:0]     word,
  input  logic [7:0]                byte_val,
  input  logic [LANE_SEL_WIDTH-1:0] lane,
  output logic [DATA_WIDTH-1:0]     merged,
  output logic [DATA_WIDTH-1:0]     extracted
);

  always_comb begin
    merged    = word;
    extracted = '0;
    case (lane)
      2'd0: begin
        merged[7:0]    = byte_val;
        extracted[7:0] = word[7:0];
      end
      2'd1: begin
        merged[15:8]   = byte_val;
        extracted[7:0] = word[15:8];
      end
      2'd2: begin
        merged[23:16]  = byte_val;
        extracted[7:0] = word[23:16];
      end
      default: begin
        merged[31:24]  = byte_val;
        extracted[7:0] = word[31:24];
      end
    endcase
  end

endmodule

// File: rtl/data_mem_access_ctrl.sv
// Initiator for a 1-cycle registered-read synchronous data memory. Serves one
// CPU load/store at a time; byte stores are done as read-modify-write.
module data_mem_access_ctrl
  import data_mem_pkg::*;
#(
  parameter int DATA_WORDS      = 512,
  parameter int DATA_ADDR_WIDTH = $clog2(DATA_WORDS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic                       req_byte,
  input  logic [31:0]                req_addr,
  input  logic [DATA_WIDTH-1:0]      req_wdata,
  output logic                       resp_valid,
  output logic                       resp_err,
  output logic [DATA_WIDTH-1:0]      resp_rdata,
  output logic                       data_mem_we,
  output logic [DATA_ADDR_WIDTH-1:0] data_addr,
  output logic [DATA_WIDTH-1:0]      data_mem_wd,
  input  logic [DATA_WIDTH-1:0]      data_mem_rd
);

  state_t state;
  state_t next_state;

  logic                      op_we;
  logic                      op_byte;
  logic [LANE_SEL_WIDTH-1:0] op_lane;
  logic [7:0]                op_wbyte;

  logic                  handshake;
  logic                  req_err;
  logic [DATA_WIDTH-1:0] merged_word;
  logic [DATA_WIDTH-1:0] extracted_byte;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign handshake  = req_valid && req_ready;

  // Misaligned word access or any address bit above the memory range is rejected.
  assign req_err = (!req_byte && (req_addr[1:0] != 2'b00)) ||
                   (req_addr[31:DATA_ADDR_WIDTH+2] != '0);

  byte_lane_merge u_lane (
    .word      (data_mem_rd),
    .byte_val  (op_wbyte),
    .lane      (op_lane),
    .merged    (merged_word),
    .extracted (extracted_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (handshake) begin
          if (req_err)                 next_state = RESP;
          else if (req_we && !req_byte) next_state = WR;
          else                         next_state = RD_ISSUE;
        end
      end
      RD_ISSUE:   next_state = RD_CAPTURE;
      RD_CAPTURE: next_state = op_we ? WR : RESP;
      WR:         next_state = RESP;
      RESP:       next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  // we defaults low every cycle, so it can only be high in the single WR cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_we       <= 1'b0;
      op_byte     <= 1'b0;
      op_lane     <= '0;
      op_wbyte    <= '0;
      resp_err    <= 1'b0;
      resp_rdata  <= '0;
      data_mem_we <= 1'b0;
      data_addr   <= '0;
      data_mem_wd <= '0;
    end else begin
      data_mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (handshake) begin
            op_we    <= req_we;
            op_byte  <= req_byte;
            op_lane  <= req_addr[LANE_SEL_WIDTH-1:0];
            op_wbyte <= req_wdata[7:0];
            resp_err <= req_err;
            if (req_err) begin
              resp_rdata <= '0;
            end else begin
              data_addr <= req_addr[DATA_ADDR_WIDTH+1:2];
              if (req_we && !req_byte) begin
                data_mem_we <= 1'b1;
                data_mem_wd <= req_wdata;
              end
            end
          end
        end
        RD_CAPTURE: begin
          if (op_we) begin
            data_mem_we <= 1'b1;
            data_mem_wd <= merged_word;
          end else begin
            resp_rdata <= op_byte ? extracted_byte : data_mem_rd;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_access_ctrl.sv
// Directed bench for data_mem_access_ctrl with a behavioural synchronous RAM.
module tb_data_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic        req_byte = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        data_mem_we;
  logic [8:0]  data_addr;
  logic [31:0] data_mem_wd;
  logic [31:0] data_mem_rd;

  logic [31:0] mem [0:511];
  logic        pre_we = 1'b0;
  logic [8:0]  pre_addr = '0;
  logic [31:0] pre_wd = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  data_mem_access_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_byte    (req_byte),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_err    (resp_err),
    .resp_rdata  (resp_rdata),
    .data_mem_we (data_mem_we),
    .data_addr   (data_addr),
    .data_mem_wd (data_mem_wd),
    .data_mem_rd (data_mem_rd)
  );

  // Synchronous RAM: registered read, write on we; preload port for the bench.
  always @(posedge clk) begin
    if (data_mem_we)  mem[data_addr] <= data_mem_wd;
    else if (pre_we)  mem[pre_addr]  <= pre_wd;
    data_mem_rd <= mem[data_addr];
  end

  function automatic logic [31:0] pre_val(input int i);
    case (i)
      2:       return 32'hAABBCCDD;
      5:       return 32'hDEADBEEF;
      511:     return 32'hCAFEF00D;
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic valid, input logic we, input logic byt,
                         input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = valid;
    req_we    = we;
    req_byte  = byt;
    req_addr  = addr;
    req_wdata = wdata;
  endtask

  // One request from the IDLE cycle; checks latency, response and the write pulse.
  task automatic apply_stimulus(input string name, input logic we, input logic byt,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input int exp_lat, input logic exp_err,
                                input logic [31:0] exp_rdata, input int exp_we_cycle,
                                input logic [8:0] exp_waddr, input logic [31:0] exp_wd);
    int lat;
    int we_cnt;
    int we_cyc;
    logic [8:0]  w_addr;
    logic [31:0] w_wd;
    lat = 0; we_cnt = 0; we_cyc = 0; w_addr = '0; w_wd = '0;
    @(negedge clk);
    check({name, " ready"}, 32'(req_ready), 32'd1);
    set_req(1'b1, we, byt, addr, wdata);
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      if (data_mem_we) begin
        we_cnt++;
        we_cyc = k;
        w_addr = data_addr;
        w_wd   = data_mem_wd;
      end
      if (resp_valid) lat = k;
      else @(negedge clk);
    end
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " err"}, 32'(resp_err), 32'(exp_err));
    check({name, " rdata"}, resp_rdata, exp_rdata);
    check({name, " we pulses"}, 32'(we_cnt), (exp_we_cycle == 0) ? 32'd0 : 32'd1);
    if (exp_we_cycle != 0) begin
      check({name, " we cycle"}, 32'(we_cyc), 32'(exp_we_cycle));
      check({name, " we addr"}, 32'(w_addr), 32'(exp_waddr));
      check({name, " we data"}, w_wd, exp_wd);
    end
  endtask

  logic [10:0] ready_mask;
  logic [10:0] resp_mask;
  logic [10:0] we_mask;
  logic [31:0] rd_log [0:3];
  int          n_resp;
  int          idx;
  int          stray;
  logic        hs;

  initial begin
    // Preload while the DUT is held in reset.
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      pre_we = 1'b1; pre_addr = 9'(i); pre_wd = pre_val(i);
    end
    @(negedge clk);
    pre_we = 1'b0;

    check("rst req_ready", 32'(req_ready), 32'd1);
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst resp_err", 32'(resp_err), 32'd0);
    check("rst resp_rdata", resp_rdata, 32'd0);
    check("rst data_mem_we", 32'(data_mem_we), 32'd0);
    check("rst data_addr", 32'(data_addr), 32'd0);
    check("rst data_mem_wd", data_mem_wd, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    apply_stimulus("ld 0x14", 0, 0, 32'h14, 32'h0, 3, 0, 32'hDEADBEEF, 0, 9'd0, 32'h0);
    apply_stimulus("st 0x20", 1, 0, 32'h20, 32'h12345678, 2, 0, 32'hDEADBEEF, 1, 9'd8, 32'h12345678);
    check("mem[8]", mem[8], 32'h12345678);
    apply_stimulus("ld 0x20", 0, 0, 32'h20, 32'h0, 3, 0, 32'h12345678, 0, 9'd0, 32'h0);
    apply_stimulus("sb 0x09", 1, 1, 32'h09, 32'hFFFFFF5A, 4, 0, 32'h12345678, 3, 9'd2, 32'hAABB5ADD);
    apply_stimulus("lb 0x0B", 0, 1, 32'h0B, 32'h0, 3, 0, 32'h000000AA, 0, 9'd0, 32'h0);
    apply_stimulus("lb 0x09", 0, 1, 32'h09, 32'h0, 3, 0, 32'h0000005A, 0, 9'd0, 32'h0);
    apply_stimulus("lb 0x08", 0, 1, 32'h08, 32'h0, 3, 0, 32'h000000DD, 0, 9'd0, 32'h0);
    apply_stimulus("lb 0x0A", 0, 1, 32'h0A, 32'h0, 3, 0, 32'h000000BB, 0, 9'd0, 32'h0);
    apply_stimulus("ld 0x06 misal", 0, 0, 32'h06, 32'h0, 1, 1, 32'h0, 0, 9'd0, 32'h0);
    apply_stimulus("ld 0x7FC", 0, 0, 32'h7FC, 32'h0, 3, 0, 32'hCAFEF00D, 0, 9'd0, 32'h0);
    apply_stimulus("lb 0x800 range", 0, 1, 32'h800, 32'h0, 1, 1, 32'h0, 0, 9'd0, 32'h0);
    apply_stimulus("sb 0x1000 range", 1, 1, 32'h1000, 32'h77, 1, 1, 32'h0, 0, 9'd0, 32'h0);

    // Reset asserted during WR: the pending write must be dropped.
    @(negedge clk);
    check("abort ready", 32'(req_ready), 32'd1);
    set_req(1'b1, 1'b1, 1'b0, 32'h10, 32'hFFFFFFFF);
    @(negedge clk);
    req_valid = 1'b0;
    check("abort we in WR", 32'(data_mem_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort we drop", 32'(data_mem_we), 32'd0);
    check("abort resp_valid", 32'(resp_valid), 32'd0);
    check("abort req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (resp_valid) stray++;
    end
    check("abort no resp", 32'(stray), 32'd0);
    check("abort mem[4]", mem[4], 32'h0);

    // Back-to-back with valid held high: store, load, byte load.
    ready_mask = '0; resp_mask = '0; we_mask = '0; n_resp = 0; idx = 0;
    @(negedge clk);
    set_req(1'b1, 1'b1, 1'b0, 32'h30, 32'h44332211);
    for (int c = 0; c <= 10; c++) begin
      ready_mask[c] = req_ready;
      resp_mask[c]  = resp_valid;
      we_mask[c]    = data_mem_we;
      if (resp_valid && n_resp < 4) begin
        rd_log[n_resp] = resp_rdata;
        n_resp++;
      end
      hs = req_ready;
      @(negedge clk);
      if (hs) begin
        idx++;
        case (idx)
          1:       set_req(1'b1, 1'b0, 1'b0, 32'h30, 32'h0);
          2:       set_req(1'b1, 1'b0, 1'b1, 32'h31, 32'h0);
          default: set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        endcase
      end
    end
    check("b2b ready cycles", 32'(ready_mask), 32'h089);
    check("b2b resp cycles", 32'(resp_mask), 32'h444);
    check("b2b we cycles", 32'(we_mask), 32'h002);
    check("b2b resp count", 32'(n_resp), 32'd3);
    check("b2b store rdata", rd_log[0], 32'h0);
    check("b2b load rdata", rd_log[1], 32'h44332211);
    check("b2b lb rdata", rd_log[2], 32'h00000022);
    check("b2b mem[12]", mem[12], 32'h44332211);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
